// File: rtl/datapath_seq_pkg.sv
// Shared types for the datapath sequencer: instruction layout, ALU ops, FSM states.
package datapath_seq_pkg;

    localparam int unsigned INSTR_W = 21;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_CMP = 3'b010,
        OP_AND = 3'b011,
        OP_MOV = 3'b100
    } op_t;

    localparam logic [2:0] OP_FLAG_ONLY = 3'b010;

    typedef struct packed {
        logic       cond;
        logic       wen;
        op_t        op;
        logic [3:0] sel;
        logic [3:0] wa;
        logic [3:0] raa;
        logic [3:0] rab;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_FLAG
    } seq_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Instruction handshake plus registered datapath control bundle of the sequencer.
interface datapath_sequencer_if;
    import datapath_seq_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic               flush;
    logic               Flag;
    logic [3:0]         Sel;
    logic               Wen;
    logic [3:0]         WA;
    logic [3:0]         RAA;
    logic [3:0]         RAB;
    logic [2:0]         Op;
    logic               busy;

    modport master (
        output instr_valid, instr_data, flush, Flag,
        input  instr_ready, Sel, Wen, WA, RAA, RAB, Op, busy
    );

    modport slave (
        input  instr_valid, instr_data, flush, Flag,
        output instr_ready, Sel, Wen, WA, RAA, RAB, Op, busy
    );

endinterface

// File: rtl/seq_instr_fifo.sv
// Synchronous instruction FIFO with occupancy count; flush empties it in one cycle.
module seq_instr_fifo
    import datapath_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  instr_t                 din,
    output instr_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    instr_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            wr_ptr_d = wr_ptr_q + AW'(push_ok);
            rd_ptr_d = rd_ptr_q + AW'(pop_ok);
            level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Buffers packed instructions and issues them as registered datapath controls with flag stalls.
// Optional DATAPATH_SEQ_COUNT_EN adds saturating issued/squashed counters.
module datapath_sequencer
    import datapath_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FLAG_LAT   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    datapath_sequencer_if.slave         bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef DATAPATH_SEQ_COUNT_EN
    ,
    output logic [15:0]                 issued_cnt,
    output logic [15:0]                 squashed_cnt
`endif
);

    localparam int              CW         = $clog2(FLAG_LAT) + 1;
    localparam logic [CW-1:0]   STALL_LOAD = CW'(FLAG_LAT - 1);

    instr_t        in_instr;
    instr_t        head;
    logic          full, empty;
    logic          push, pop, squash;

    seq_state_t    state_q, state_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [3:0]    sel_q, sel_d;
    logic [3:0]    wa_q, wa_d;
    logic [3:0]    raa_q, raa_d;
    logic [3:0]    rab_q, rab_d;
    logic [2:0]    op_q, op_d;
    logic          wen_q, wen_d;
`ifdef DATAPATH_SEQ_COUNT_EN
    logic [15:0]   issued_cnt_q, issued_cnt_d;
    logic [15:0]   squashed_cnt_q, squashed_cnt_d;
`endif

    assign in_instr        = bus.instr_data;
    assign bus.instr_ready = !full && !bus.flush;
    assign push            = bus.instr_valid && bus.instr_ready;
    assign pop             = !bus.flush && !empty && (state_q != WAIT_FLAG);
    assign squash          = head.cond && !bus.Flag;

    seq_instr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.flush),
        .push  (push),
        .pop   (pop),
        .din   (in_instr),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        sel_d   = sel_q;
        wa_d    = wa_q;
        raa_d   = raa_q;
        rab_d   = rab_q;
        op_d    = op_q;
        wen_d   = 1'b0;
`ifdef DATAPATH_SEQ_COUNT_EN
        issued_cnt_d   = issued_cnt_q;
        squashed_cnt_d = squashed_cnt_q;
`endif
        if (bus.flush) begin
            state_d = IDLE;
            stall_d = '0;
        end else begin
            case (state_q)
                // IDLE pops in the same cycle it sees data so issue follows acceptance by one edge.
                IDLE, ISSUE: begin
                    if (pop) begin
                        if (!squash && head.op == OP_FLAG_ONLY) begin
                            state_d = WAIT_FLAG;
                            stall_d = STALL_LOAD;
                        end else begin
                            state_d = ISSUE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT_FLAG: begin
                    if (stall_q == '0) begin
                        state_d = empty ? IDLE : ISSUE;
                    end else begin
                        stall_d = stall_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (pop) begin
                if (squash) begin
`ifdef DATAPATH_SEQ_COUNT_EN
                    squashed_cnt_d = sat_inc16(squashed_cnt_q);
`endif
                end else begin
                    sel_d = head.sel;
                    wa_d  = head.wa;
                    raa_d = head.raa;
                    rab_d = head.rab;
                    op_d  = head.op;
                    wen_d = head.wen;
`ifdef DATAPATH_SEQ_COUNT_EN
                    issued_cnt_d = sat_inc16(issued_cnt_q);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stall_q <= '0;
            sel_q   <= '0;
            wa_q    <= '0;
            raa_q   <= '0;
            rab_q   <= '0;
            op_q    <= '0;
            wen_q   <= 1'b0;
`ifdef DATAPATH_SEQ_COUNT_EN
            issued_cnt_q   <= '0;
            squashed_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            sel_q   <= sel_d;
            wa_q    <= wa_d;
            raa_q   <= raa_d;
            rab_q   <= rab_d;
            op_q    <= op_d;
            wen_q   <= wen_d;
`ifdef DATAPATH_SEQ_COUNT_EN
            issued_cnt_q   <= issued_cnt_d;
            squashed_cnt_q <= squashed_cnt_d;
`endif
        end
    end

    assign bus.Sel  = sel_q;
    assign bus.WA   = wa_q;
    assign bus.RAA  = raa_q;
    assign bus.RAB  = rab_q;
    assign bus.Op   = op_q;
    assign bus.Wen  = wen_q;
    assign bus.busy = !empty || (state_q != IDLE);
`ifdef DATAPATH_SEQ_COUNT_EN
    assign issued_cnt   = issued_cnt_q;
    assign squashed_cnt = squashed_cnt_q;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized and directed bench for datapath_sequencer against a queue-based reference model.
module tb_datapath_sequencer;
    import datapath_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] fifo_level;
`ifdef DATAPATH_SEQ_COUNT_EN
    logic [15:0] issued_cnt, squashed_cnt;
`endif

    int checks = 0;
    int errors = 0;

    datapath_sequencer_if bus();

    datapath_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .FLAG_LAT  (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_level (fifo_level)
`ifdef DATAPATH_SEQ_COUNT_EN
        ,
        .issued_cnt   (issued_cnt),
        .squashed_cnt (squashed_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: pending instructions, remaining stall cycles, last issued controls.
    logic [20:0] mq[$];
    int          wait_left;
    bit          popped_last;
    logic        e_wen;
    logic [3:0]  e_sel, e_wa, e_raa, e_rab;
    logic [2:0]  e_op;
    int          e_iss, e_sq;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [20:0] mk(input logic c, input logic w, input logic [2:0] op,
                                       input logic [3:0] sel, input logic [3:0] wa,
                                       input logic [3:0] raa, input logic [3:0] rab);
        return {c, w, op, sel, wa, raa, rab};
    endfunction

    initial begin
        logic [20:0] ins;
        bit          can_push;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                wait_left = 0;
                popped_last = 0;
                e_wen = 0; e_sel = 0; e_wa = 0; e_raa = 0; e_rab = 0; e_op = 0;
                e_iss = 0; e_sq = 0;
            end else begin
                can_push = bus.instr_valid && !bus.flush && (mq.size() < DEPTH);
                e_wen = 0;
                if (bus.flush) begin
                    mq.delete();
                    wait_left = 0;
                    popped_last = 0;
                end else begin
                    popped_last = 0;
                    if (wait_left > 0) begin
                        wait_left--;
                    end else if (mq.size() > 0) begin
                        ins = mq.pop_front();
                        popped_last = 1;
                        if (ins[20] && !bus.Flag) begin
                            if (e_sq < 65535) e_sq++;
                        end else begin
                            e_wen = ins[19];
                            e_op  = ins[18:16];
                            e_sel = ins[15:12];
                            e_wa  = ins[11:8];
                            e_raa = ins[7:4];
                            e_rab = ins[3:0];
                            if (e_iss < 65535) e_iss++;
                            if (ins[18:16] == 3'b010) wait_left = LAT;
                        end
                    end
                    if (can_push) mq.push_back(bus.instr_data);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("handshake", {bus.instr_ready, fifo_level, bus.busy},
                      {(mq.size() < DEPTH) && !bus.flush, 3'(mq.size()),
                       (mq.size() != 0) || (wait_left != 0) || popped_last});
                check("controls", {bus.Wen, bus.Sel, bus.WA, bus.RAA, bus.RAB, bus.Op},
                      {e_wen, e_sel, e_wa, e_raa, e_rab, e_op});
`ifdef DATAPATH_SEQ_COUNT_EN
                check("counters", {issued_cnt, squashed_cnt}, {16'(e_iss), 16'(e_sq)});
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 50) begin
            tick();
            n++;
        end
        check(name, bus.busy, 1'b0);
    endtask

    initial begin
        logic [20:0] t2[7];
        int          idx;
        bit          saw_full;
        bit          acc;

        bus.instr_valid = 0;
        bus.instr_data  = '0;
        bus.flush       = 0;
        bus.Flag        = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // reset state
        check("rst_ready", bus.instr_ready, 1'b1);
        check("rst_level", fifo_level, 3'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ctrl", {bus.Wen, bus.Sel, bus.WA, bus.RAA, bus.RAB, bus.Op}, 20'h0);

        // single ADD: accepted at t, visible after t+1 for one cycle
        bus.instr_valid = 1;
        bus.instr_data  = mk(0, 1, OP_ADD, 4'd0, 4'd3, 4'd1, 4'd2);
        tick();
        bus.instr_valid = 0;
        check("t1_not_yet", bus.Wen, 1'b0);
        check("t1_level", fifo_level, 3'd1);
        tick();
        check("t1_issue", {bus.Wen, bus.WA, bus.RAA, bus.RAB, bus.Op}, {1'b1, 4'd3, 4'd1, 4'd2, 3'd0});
        tick();
        check("t1_pulse_end", {bus.Wen, bus.WA}, {1'b0, 4'd3});
        drain("t1_drain");

        // fill the FIFO behind CMP stalls; pushes continue while valid is held
        t2[0] = mk(0, 0, OP_CMP, 4'd1, 4'd0, 4'd1, 4'd2);
        t2[1] = mk(0, 0, OP_CMP, 4'd2, 4'd0, 4'd3, 4'd4);
        t2[2] = mk(0, 1, OP_SUB, 4'd3, 4'd5, 4'd6, 4'd7);
        t2[3] = mk(0, 1, OP_AND, 4'd4, 4'd6, 4'd7, 4'd8);
        t2[4] = mk(0, 1, OP_MOV, 4'd5, 4'd7, 4'd8, 4'd9);
        t2[5] = mk(0, 1, OP_ADD, 4'd6, 4'd8, 4'd9, 4'd10);
        t2[6] = mk(0, 0, OP_ADD, 4'd7, 4'd9, 4'd10, 4'd11);
        idx = 0;
        saw_full = 0;
        for (int cyc = 0; cyc < 40 && idx < 7; cyc++) begin
            bus.instr_valid = 1;
            bus.instr_data  = t2[idx];
            #1;
            acc = bus.instr_ready;
            tick();
            if (acc) idx++;
            if (fifo_level == 3'd4) begin
                check("t2_full_not_ready", bus.instr_ready, 1'b0);
                saw_full = 1;
            end
        end
        bus.instr_valid = 0;
        check("t2_all_accepted", idx, 7);
        check("t2_reached_full", saw_full, 1'b1);
        drain("t2_drain");

        // CMP then conditional ADD with Flag set and then clear
        for (int f = 1; f >= 0; f--) begin
            bus.Flag = f[0];
            bus.instr_valid = 1;
            bus.instr_data  = mk(0, 0, OP_CMP, 4'd2, 4'd0, 4'd4, 4'd5);
            tick();
            bus.instr_data  = mk(1, 1, OP_ADD, 4'd1, 4'd9, 4'd6, 4'd7);
            tick();
            bus.instr_valid = 0;
            check("t3_cmp_issued", {bus.Wen, bus.Op, bus.RAA}, {1'b0, 3'd2, 4'd4});
            tick();
            check("t3_gap1", bus.Wen, 1'b0);
            tick();
            check("t3_gap2", bus.Wen, 1'b0);
            tick();
            if (f == 1) begin
                check("t3_add_issued", {bus.Wen, bus.WA, bus.Op}, {1'b1, 4'd9, 3'd0});
            end else begin
                check("t4_squashed", {bus.Wen, bus.WA, bus.Op}, {1'b0, 4'd0, 3'd2});
            end
            tick();
            tick();
            check("t34_busy_drop", bus.busy, 1'b0);
        end
`ifdef DATAPATH_SEQ_COUNT_EN
        check("t4_squashed_cnt", squashed_cnt, 16'd1);
`endif
        bus.Flag = 0;

        // flush with three entries queued and a push offered
        bus.instr_valid = 1;
        bus.instr_data  = mk(0, 0, OP_CMP, 4'd0, 4'd0, 4'd1, 4'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.instr_data = mk(0, 1, OP_ADD, 4'd0, 4'(k + 1), 4'd2, 4'd3);
            tick();
        end
        check("t5_queued", fifo_level, 3'd3);
        bus.flush = 1;
        bus.instr_data = mk(0, 1, OP_MOV, 4'd15, 4'd15, 4'd15, 4'd15);
        #1;
        check("t5_ready_low", bus.instr_ready, 1'b0);
        tick();
        bus.flush = 0;
        bus.instr_valid = 0;
        check("t5_emptied", {fifo_level, bus.Wen, bus.busy}, {3'd0, 1'b0, 1'b0});
        tick();
        check("t5_no_pulse", {fifo_level, bus.Wen}, {3'd0, 1'b0});

        // asynchronous reset during WAIT_FLAG
        bus.instr_valid = 1;
        bus.instr_data  = mk(0, 1, OP_CMP, 4'd6, 4'd6, 4'd6, 4'd6);
        tick();
        bus.instr_valid = 0;
        tick();
        check("t6_cmp", bus.Op, 3'd2);
        #2 rst = 1;
        #1;
        check("t6_async_clear", {bus.Wen, bus.Sel, bus.WA, bus.Op, fifo_level, bus.busy}, 16'h0);
        @(posedge clk);
        #1 rst = 0;
        bus.instr_valid = 1;
        bus.instr_data  = mk(0, 1, OP_SUB, 4'd1, 4'd5, 4'd2, 4'd3);
        tick();
        bus.instr_valid = 0;
        tick();
        check("t6_no_residual_stall", {bus.Wen, bus.WA, bus.Op}, {1'b1, 4'd5, 3'd1});
        drain("t6_drain");

        // randomized traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bus.instr_valid = ($urandom_range(0, 99) < 70);
            bus.instr_data  = mk($urandom_range(0, 99) < 30, 1'($urandom), 3'($urandom_range(0, 4)),
                                 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            bus.Flag        = 1'($urandom);
            bus.flush       = ($urandom_range(0, 99) < 3);
            tick();
        end
        bus.instr_valid = 0;
        bus.flush = 0;
        drain("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
